dea_round_ctrl: RTL
===================

DEA_ROUND_CTRL -- requirements
Module: dea_round_ctrl

Interface
REQ-001 The block SHALL provide parameter ROUNDS, default 16, giving the number of cipher rounds sequenced per block; legal range 1..16.
REQ-002 The block SHALL provide parameter CNTW, default 16, giving the width of the completed-block counter.
REQ-003 Clk_100M  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start_valid  input  1  requester offers a new block.
REQ-006 start_ready  output  1  controller can accept a block.
REQ-007 decrypt  input  1  mode for the offered block: 0 = encrypt, 1 = decrypt; sampled with start_valid.
REQ-008 abort  input  1  cancel the block in flight.
REQ-009 dp_load  output  1  one-cycle strobe: datapath loads the input block and applies the initial permutation.
REQ-010 dp_round_en  output  1  datapath executes one round this cycle.
REQ-011 key_idx  output  4  subkey index for the current round.
REQ-012 dp_final  output  1  one-cycle strobe: datapath applies the final permutation and registers the result.
REQ-013 out_valid  output  1  result available at the datapath output.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 blocks_done  output  CNTW  count of results handed off since reset.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, ROUND, FINAL and HOLD.
REQ-018 start_ready SHALL be 1 only in IDLE, and a start is accepted only on a cycle with start_valid=1 and start_ready=1.
REQ-019 On an accepted start, decrypt SHALL be latched into an internal mode register, and the next state SHALL be LOAD.
REQ-020 LOAD SHALL last exactly one cycle with dp_load=1, then go to ROUND with the round counter at 0.
REQ-021 ROUND SHALL last exactly ROUNDS cycles with dp_round_en=1; the round counter r increments from 0 to ROUNDS-1, and after r=ROUNDS-1 the next state is FINAL.
REQ-022 In ROUND, key_idx SHALL be r when mode=0 and ROUNDS-1-r when mode=1; outside ROUND, key_idx SHALL be 0.
REQ-023 FINAL SHALL last exactly one cycle with dp_final=1, then go to HOLD.
REQ-024 In HOLD, out_valid SHALL be 1 and held until out_ready=1; on that handshake cycle the next state is IDLE and blocks_done increments by 1.
REQ-025 Latency from the accept cycle to the first out_valid cycle SHALL be ROUNDS+3 cycles (19 at default).
REQ-026 dp_load, dp_round_en, dp_final and out_valid SHALL be mutually exclusive, and at most one SHALL be high in any cycle.
REQ-027 An accept cannot occur in the same cycle as an out handshake; the next block is accepted no earlier than the cycle after HOLD exits.
REQ-028 abort=1 in any state other than IDLE SHALL force the next state to IDLE, clear the round counter and leave blocks_done unchanged; strobes in the abort cycle itself remain as the current state dictates.
REQ-029 abort=1 in HOLD together with out_ready=1 SHALL count as a completed handshake, and blocks_done SHALL increment.
REQ-030 abort in IDLE SHALL have no effect, and a simultaneous start SHALL still be accepted.
REQ-031 blocks_done SHALL wrap from 2^CNTW-1 to 0 without any flag.
REQ-032 start_valid and decrypt changes outside IDLE SHALL be ignored.

Reset
REQ-033 While Reset=1, state SHALL be IDLE, round counter 0, mode 0, blocks_done 0, and dp_load, dp_round_en, dp_final, out_valid and busy 0; key_idx SHALL be 0 and start_ready 1.
REQ-034 Reset asserted mid-block SHALL take effect immediately without waiting for a clock edge; the in-flight block is discarded, and the first accept is possible on the first rising edge after Reset deasserts.

Verification
REQ-035 Encrypt, ROUNDS=16, out_ready=1: accept at cycle 0 -> dp_load at cycle 1, dp_round_en cycles 2..17 with key_idx 0..15, dp_final cycle 18, out_valid cycle 19, blocks_done=1 at cycle 20.
REQ-036 Decrypt, same timing: key_idx SHALL read 15,14,...,0 across cycles 2..17; toggling decrypt during ROUND SHALL not alter the sequence.
REQ-037 Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid stays 1, start_ready stays 0 and no strobes occur; out_ready=1 -> IDLE next cycle.
REQ-038 Abort at the 7th ROUND cycle (key_idx=6) -> IDLE next cycle, busy=0, blocks_done unchanged, and a new start is accepted normally.
REQ-039 Reset pulse during ROUND -> all outputs at reset values asynchronously, and a subsequent block completes with the full ROUNDS+3 latency.
REQ-040 With CNTW=4, complete 17 blocks -> blocks_done reads 15 after the 15th block, 0 after the 16th and 1 after the 17th.

Source files
------------

// File: rtl/dea_round_ctrl.sv
// Round sequencer for an iterated block cipher datapath: load, ROUNDS rounds,
// final permutation, then hold the result until the consumer takes it.
module dea_round_ctrl #(
   parameter int ROUNDS = 16,
   parameter int CNTW   = 16
) (
   input  logic            Clk_100M,
   input  logic            Reset,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic            decrypt,
   input  logic            abort,
   output logic            dp_load,
   output logic            dp_round_en,
   output logic [3:0]      key_idx,
   output logic            dp_final,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic [CNTW-1:0] blocks_done
);

   typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, HOLD} state_t;

   localparam logic [3:0] LAST = 4'(ROUNDS - 1);

   state_t     state;
   logic [3:0] rnd;
   logic       mode;
   logic [3:0] rnd_nxt;

   assign rnd_nxt = rnd + 4'd1;

   // Outputs are registered: each branch loads the values belonging to the
   // state being entered, so key_idx is computed one round ahead.
   always_ff @(posedge Clk_100M or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         rnd         <= '0;
         mode        <= 1'b0;
         blocks_done <= '0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
         dp_load     <= 1'b0;
         dp_round_en <= 1'b0;
         dp_final    <= 1'b0;
         out_valid   <= 1'b0;
         key_idx     <= '0;
      end else begin
         dp_load     <= 1'b0;
         dp_round_en <= 1'b0;
         dp_final    <= 1'b0;
         key_idx     <= '0;
         // A HOLD handshake wins over abort so the result is still counted.
         if (abort && state != IDLE && !(state == HOLD && out_ready)) begin
            state       <= IDLE;
            rnd         <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_valid) begin
                     mode        <= decrypt;
                     state       <= LOAD;
                     dp_load     <= 1'b1;
                     start_ready <= 1'b0;
                     busy        <= 1'b1;
                  end
               end
               LOAD: begin
                  state       <= ROUND;
                  rnd         <= '0;
                  dp_round_en <= 1'b1;
                  key_idx     <= mode ? LAST : 4'd0;
               end
               ROUND: begin
                  if (rnd == LAST) begin
                     state    <= FINAL;
                     rnd      <= '0;
                     dp_final <= 1'b1;
                  end else begin
                     rnd         <= rnd_nxt;
                     dp_round_en <= 1'b1;
                     key_idx     <= mode ? (LAST - rnd_nxt) : rnd_nxt;
                  end
               end
               FINAL: begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
               HOLD: begin
                  if (out_ready) begin
                     state       <= IDLE;
                     out_valid   <= 1'b0;
                     start_ready <= 1'b1;
                     busy        <= 1'b0;
                     blocks_done <= blocks_done + CNTW'(1);
                  end
               end
               default: begin
                  state       <= IDLE;
                  rnd         <= '0;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
                  out_valid   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
